yacc_result_collector: RTL and testbench
========================================

Name: yacc_result_collector

Overview:
- Receiving end of the cache access stream: consumes one per-access result record from the YACC cache core (mainMod) and keeps saturating performance counters.
- Counters: accesses, hits, misses, evictions, accumulated compressed size.
- Reports a per-window hit count every WINDOW accesses.
- Exposes a snapshot/readout handshake so a host or bench reads consistent counter sets while traffic keeps running.

Parameters:
- CNT_W, 32, width of every counter and of rd_data.
- SIZE_W, 3, width of res_size (compressed size of accessed block, in sub-block units 0..7).
- WINDOW, 1024, accesses per measurement window; range 2 to 2^CNT_W-1.

Ports:
- clock  input  1  single clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- res_valid  input  1  one access result present this cycle.
- res_hit  input  1  1 = hit, 0 = miss; sampled only with res_valid.
- res_evict  input  1  access caused a superblock eviction; sampled only with res_valid.
- res_size  input  SIZE_W  compressed size of accessed block; sampled only with res_valid.
- clear  input  1  synchronous clear of live counters and window state.
- snap  input  1  copy live counters into the snapshot bank.
- rd_req  input  1  read request for one snapshot word.
- rd_sel  input  3  0=access, 1=hit, 2=miss, 3=evict, 4=size_sum, 5=last window hits, 6-7 reserved.
- rd_ack  output  1  one-cycle pulse; rd_data is valid.
- rd_data  output  CNT_W  selected snapshot word.
- win_done  output  1  one-cycle pulse at window completion.
- win_hits  output  CNT_W  hit count of the last completed window.
- busy  output  1  read in progress; a new rd_req is ignored.

Behaviour:
- Reset (reset_n=0, asynchronous): all live counters, snapshot bank, window counters, rd_data, win_hits = 0; rd_ack, win_done, busy = 0.
- Accepted access (res_valid=1):
  - access_cnt +1.
  - hit_cnt +1 if res_hit, else miss_cnt +1.
  - evict_cnt +1 if res_evict.
  - size_sum += zero-extended res_size.
  - Every counter saturates at 2^CNT_W-1; it never wraps.
  - size_sum saturates on overflow of the add.
- Window logic:
  - win_cnt counts accepted accesses; win_hit_acc counts hits in the current window.
  - The access that makes win_cnt reach WINDOW, including its own hit, closes the window.
  - One cycle after that access: win_done pulses, win_hits holds the final window hit count, and win_cnt and win_hit_acc restart at 0.
  - win_hits holds its value until the next window closes or clear.
- clear:
  - Live counters, win_cnt, win_hit_acc, win_hits -> 0 next cycle.
  - Snapshot bank is unaffected.
  - If res_valid is in the same cycle, clear wins and the access is dropped.
  - If clear coincides with a window close, no win_done pulse is produced.
- snap:
  - Snapshot bank <= live values as they are before that cycle's update.
  - The bank also captures win_hits into slot 5.
  - With clear in the same cycle, the snapshot takes the pre-clear values.
- Read FSM, states IDLE -> READ -> ACK -> IDLE:
  - IDLE: rd_req=1 latches rd_sel, busy=1, go to READ.
  - READ: rd_data <= snapshot[sel], or 0 for reserved selects; go to ACK.
  - ACK: rd_ack=1 for exactly one cycle, busy=0 next cycle; return to IDLE.
  - Latency: rd_req to rd_ack is 2 cycles.
  - rd_data holds until the next read completes.
  - rd_req while busy is ignored, with no queueing.
  - snap during READ/ACK updates the bank. The read returns the value in the bank at the READ cycle.
- Reset asserted mid-read: FSM -> IDLE immediately; rd_ack is never issued for that read.

Test Plan:
- Reset -> rd_data=0, rd_ack=0, win_done=0, busy=0. 10 accesses (6 hits, 4 misses, 2 evicts, sizes all 3), then snap, then read sel 0..4 -> 10, 6, 4, 2, 30, each rd_ack exactly 2 cycles after rd_req.
- WINDOW=4, 8 consecutive accesses with hit pattern 1,1,0,1,0,0,0,1 -> win_done pulses after access 4 and access 8; win_hits=3, then 1.
- CNT_W=4, 20 hits -> hit_cnt reads 15 (saturated), miss_cnt reads 0. Size_sum with 3 accesses of size 7 reads 15.
- clear together with res_valid hit and snap -> snapshot access_cnt shows the pre-clear count (e.g. 5). A second snap next cycle reads 0; the dropped access is not counted.
- rd_req held high for 6 cycles -> exactly 2 rd_ack pulses, with busy deasserted between them. rd_sel=6 -> rd_data=0.
- reset_n pulled low in the READ state -> no rd_ack, outputs 0 asynchronously. A fresh read after release returns 0.

Source files
------------

// File: rtl/yacc_result_collector.sv
// Result collector for the YACC cache access stream: saturating performance
// counters, per-window hit reporting and a snapshot bank read through a small handshake.
module yacc_result_collector #(
  parameter int CNT_W  = 32,
  parameter int SIZE_W = 3,
  parameter int WINDOW = 1024
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              res_valid,
  input  logic              res_hit,
  input  logic              res_evict,
  input  logic [SIZE_W-1:0] res_size,
  input  logic              clear,
  input  logic              snap,
  input  logic              rd_req,
  input  logic [2:0]        rd_sel,
  output logic              rd_ack,
  output logic [CNT_W-1:0]  rd_data,
  output logic              win_done,
  output logic [CNT_W-1:0]  win_hits,
  output logic              busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] READ = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [CNT_W-1:0] acc_cnt, hit_cnt, miss_cnt, evict_cnt, size_sum;
  logic [CNT_W-1:0] win_cnt, win_hit_acc;
  logic [CNT_W-1:0] bank [6];
  logic [1:0]       state;
  logic [2:0]       rd_sel_p0;
  logic [CNT_W-1:0] rd_word_p0;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [SIZE_W-1:0] s);
    logic [CNT_W:0] sum;
    sum = {1'b0, v} + (CNT_W+1)'(s);
    return sum[CNT_W] ? CNT_MAX : sum[CNT_W-1:0];
  endfunction

  // Live counters and window tracking; clear wins over a same-cycle access.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc_cnt     <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      evict_cnt   <= '0;
      size_sum    <= '0;
      win_cnt     <= '0;
      win_hit_acc <= '0;
      win_hits    <= '0;
      win_done    <= 1'b0;
    end else if (clear) begin
      acc_cnt     <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      evict_cnt   <= '0;
      size_sum    <= '0;
      win_cnt     <= '0;
      win_hit_acc <= '0;
      win_hits    <= '0;
      win_done    <= 1'b0;
    end else begin
      win_done <= 1'b0;
      if (res_valid) begin
        acc_cnt <= sat_inc(acc_cnt);
        if (res_hit) hit_cnt <= sat_inc(hit_cnt);
        else         miss_cnt <= sat_inc(miss_cnt);
        if (res_evict) evict_cnt <= sat_inc(evict_cnt);
        size_sum <= sat_add(size_sum, res_size);
        if (win_cnt == WIN_LAST) begin
          win_done    <= 1'b1;
          win_hits    <= win_hit_acc + CNT_W'(res_hit);
          win_cnt     <= '0;
          win_hit_acc <= '0;
        end else begin
          win_cnt     <= win_cnt + 1'b1;
          win_hit_acc <= win_hit_acc + CNT_W'(res_hit);
        end
      end
    end
  end

  // Snapshot bank samples register values, i.e. the state before this cycle's update.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 6; i++) bank[i] <= '0;
    end else if (snap) begin
      bank[0] <= acc_cnt;
      bank[1] <= hit_cnt;
      bank[2] <= miss_cnt;
      bank[3] <= evict_cnt;
      bank[4] <= size_sum;
      bank[5] <= win_hits;
    end
  end

  always_comb begin
    rd_word_p0 = '0;
    case (rd_sel_p0)
      3'd0:    rd_word_p0 = bank[0];
      3'd1:    rd_word_p0 = bank[1];
      3'd2:    rd_word_p0 = bank[2];
      3'd3:    rd_word_p0 = bank[3];
      3'd4:    rd_word_p0 = bank[4];
      3'd5:    rd_word_p0 = bank[5];
      default: rd_word_p0 = '0;
    endcase
  end

  // Read handshake: latch select, fetch word, acknowledge for one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rd_sel_p0 <= '0;
      rd_data   <= '0;
      rd_ack    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rd_req) begin
            rd_sel_p0 <= rd_sel;
            busy      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          rd_data <= rd_word_p0;
          rd_ack  <= 1'b1;
          state   <= ACK;
        end
        ACK: begin
          rd_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          rd_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_yacc_result_collector.sv
// Directed bench for yacc_result_collector: a WINDOW=4 instance and a
// 4-bit counter instance share one stimulus stream.
module tb_yacc_result_collector;

  logic        clock = 1'b0;
  logic        reset_n, res_valid, res_hit, res_evict, clear, snap, rd_req;
  logic [2:0]  res_size, rd_sel;

  logic        m_rd_ack, m_win_done, m_busy;
  logic [31:0] m_rd_data, m_win_hits;
  logic        s_rd_ack, s_win_done, s_busy;
  logic [3:0]  s_rd_data, s_win_hits;

  int          vecs = 0;
  int          errs = 0;
  int          ack_n;
  logic [31:0] md, sd;
  logic [7:0]  pat;

  always #5 clock = ~clock;

  yacc_result_collector #(.CNT_W(32), .SIZE_W(3), .WINDOW(4)) u_main (
    .clock(clock), .reset_n(reset_n), .res_valid(res_valid), .res_hit(res_hit),
    .res_evict(res_evict), .res_size(res_size), .clear(clear), .snap(snap),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(m_rd_ack), .rd_data(m_rd_data),
    .win_done(m_win_done), .win_hits(m_win_hits), .busy(m_busy)
  );

  yacc_result_collector #(.CNT_W(4), .SIZE_W(3), .WINDOW(15)) u_sat (
    .clock(clock), .reset_n(reset_n), .res_valid(res_valid), .res_hit(res_hit),
    .res_evict(res_evict), .res_size(res_size), .clear(clear), .snap(snap),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(s_rd_ack), .rd_data(s_rd_data),
    .win_done(s_win_done), .win_hits(s_win_hits), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic acc(input logic h, input logic e, input logic [2:0] sz);
    res_valid = 1'b1; res_hit = h; res_evict = e; res_size = sz;
    tick;
    res_valid = 1'b0; res_hit = 1'b0; res_evict = 1'b0; res_size = '0;
  endtask

  task automatic pulse_clear;
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic pulse_snap;
    snap = 1'b1;
    tick;
    snap = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] sel, output logic [31:0] mdat, output logic [31:0] sdat);
    rd_req = 1'b1; rd_sel = sel;
    tick;
    rd_req = 1'b0;
    chk("busy_in_read", {31'b0, m_busy}, 32'd1);
    tick;
    chk("ack_latency", {31'b0, m_rd_ack}, 32'd1);
    mdat = m_rd_data;
    sdat = {28'b0, s_rd_data};
    tick;
    chk("ack_single", {31'b0, m_rd_ack}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; res_valid = 1'b0; res_hit = 1'b0; res_evict = 1'b0; res_size = '0;
    clear = 1'b0; snap = 1'b0; rd_req = 1'b0; rd_sel = '0;
    #22;
    chk("rst_rd_data",  m_rd_data, 32'd0);
    chk("rst_rd_ack",   {31'b0, m_rd_ack}, 32'd0);
    chk("rst_win_done", {31'b0, m_win_done}, 32'd0);
    chk("rst_busy",     {31'b0, m_busy}, 32'd0);
    chk("rst_s_outs",   {s_rd_ack, s_win_done, s_busy, s_rd_data, s_win_hits}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick;

    // 10 accesses: hits 0..5, misses 6..9, evicts on 0 and 5, size 3
    for (int i = 0; i < 10; i++) acc(i < 6, (i == 0) || (i == 5), 3'd3);
    pulse_snap;
    do_read(3'd0, md, sd); chk("acc_cnt",   md, 32'd10);
    do_read(3'd1, md, sd); chk("hit_cnt",   md, 32'd6);
    do_read(3'd2, md, sd); chk("miss_cnt",  md, 32'd4);
    do_read(3'd3, md, sd); chk("evict_cnt", md, 32'd2);
    do_read(3'd4, md, sd); chk("size_sum",  md, 32'd30);
    do_read(3'd5, md, sd); chk("snap_win_hits", md, 32'd2);

    // window of 4 with hit pattern 1,1,0,1,0,0,0,1
    pulse_clear;
    pat = 8'b1000_1011;
    for (int i = 0; i < 8; i++) begin
      acc(pat[i], 1'b0, 3'd0);
      chk("win_done", {31'b0, m_win_done}, ((i == 3) || (i == 7)) ? 32'd1 : 32'd0);
      if (i == 3) chk("win_hits_1", m_win_hits, 32'd3);
      if (i == 7) chk("win_hits_2", m_win_hits, 32'd1);
    end
    tick;
    chk("win_done_end", {31'b0, m_win_done}, 32'd0);
    chk("win_hits_hold", m_win_hits, 32'd1);

    // saturation on the 4-bit instance
    pulse_clear;
    chk("clear_win_hits", m_win_hits, 32'd0);
    for (int i = 0; i < 20; i++) acc(1'b1, 1'b0, 3'd0);
    pulse_snap;
    do_read(3'd0, md, sd); chk("sat_acc", sd, 32'd15);
    do_read(3'd1, md, sd); chk("sat_hit", sd, 32'd15); chk("wide_hit", md, 32'd20);
    do_read(3'd2, md, sd); chk("sat_miss", sd, 32'd0);
    pulse_clear;
    for (int i = 0; i < 3; i++) acc(1'b0, 1'b0, 3'd7);
    pulse_snap;
    do_read(3'd4, md, sd); chk("sat_size", sd, 32'd15); chk("wide_size", md, 32'd21);

    // clear + access + snap together, read started the same cycle, snap again during READ
    pulse_clear;
    for (int i = 0; i < 5; i++) acc(1'b1, 1'b0, 3'd1);
    clear = 1'b1; res_valid = 1'b1; res_hit = 1'b1; snap = 1'b1; rd_req = 1'b1; rd_sel = 3'd0;
    tick;
    clear = 1'b0; res_valid = 1'b0; res_hit = 1'b0; rd_req = 1'b0;
    tick;
    snap = 1'b0;
    chk("preclear_ack", {31'b0, m_rd_ack}, 32'd1);
    chk("preclear_acc", m_rd_data, 32'd5);
    tick;
    do_read(3'd0, md, sd); chk("postclear_acc", md, 32'd0);
    do_read(3'd1, md, sd); chk("dropped_hit", md, 32'd0);

    // rd_req held for 6 cycles on a reserved select
    for (int i = 0; i < 3; i++) acc(1'b0, 1'b0, 3'd0);
    pulse_snap;
    do_read(3'd0, md, sd); chk("acc_before_hold", md, 32'd3);
    ack_n = 0;
    rd_req = 1'b1; rd_sel = 3'd6;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) rd_req = 1'b0;
      tick;
      if (m_rd_ack) ack_n++;
      if (c == 2) chk("busy_gap", {31'b0, m_busy}, 32'd0);
    end
    chk("held_req_acks", ack_n, 32'd2);
    chk("reserved_sel", m_rd_data, 32'd0);

    // reset asserted while the FSM is in READ
    do_read(3'd0, md, sd); chk("acc_before_rst", md, 32'd3);
    rd_req = 1'b1; rd_sel = 3'd0;
    tick;
    rd_req = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("async_rd_data", m_rd_data, 32'd0);
    chk("async_busy", {31'b0, m_busy}, 32'd0);
    ack_n = 0;
    for (int c = 0; c < 3; c++) begin
      tick;
      if (m_rd_ack) ack_n++;
    end
    chk("no_ack_after_rst", ack_n, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    tick;
    do_read(3'd0, md, sd); chk("read_after_rst", md, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
